// File: rtl/instr_fetch_unit.sv
// Program counter and fetch control feeding a 1-cycle-latency instruction memory.
// Handles decode stall, execute redirect, and a sticky trap on misaligned targets.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              instr_valid,
    output logic              fetch_err,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] if_pc_q;
    logic [31:0] if_pc_next;
    logic        if_valid_q;
    logic        if_valid_next;
    logic        fetch_err_next;
    logic        redirect_aligned;
    logic        redirect_misaligned;

    assign redirect_aligned    = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

    assign instr       = imem_data;
    assign instr_pc    = if_pc_q;
    assign instr_valid = if_valid_q && !redirect_valid && (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            pc_q        <= RESET_PC;
            if_pc_q     <= RESET_PC;
            if_valid_q  <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_count <= '0;
        end else begin
            state      <= state_next;
            pc_q       <= pc_next;
            if_pc_q    <= if_pc_next;
            if_valid_q <= if_valid_next;
            fetch_err  <= fetch_err_next;
            if (instr_valid && !stall) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc_q;
        if_pc_next     = if_pc_q;
        if_valid_next  = if_valid_q;
        fetch_err_next = fetch_err;
        imem_addr      = pc_q[ADDR_W+1:2];

        unique case (state)
            BOOT: begin
                pc_next       = RESET_PC + 32'd4;
                if_pc_next    = RESET_PC;
                if_valid_next = 1'b1;
                state_next    = RUN;
            end
            RUN: begin
                // While stalled the memory re-reads the displayed word so instr stays put.
                if (stall) begin
                    imem_addr = if_pc_q[ADDR_W+1:2];
                end
                if (redirect_misaligned) begin
                    state_next     = TRAP;
                    fetch_err_next = 1'b1;
                    if_valid_next  = 1'b0;
                end else if (redirect_aligned) begin
                    pc_next       = redirect_pc + 32'd4;
                    if_pc_next    = redirect_pc;
                    if_valid_next = 1'b1;
                    imem_addr     = redirect_pc[ADDR_W+1:2];
                end else if (!stall) begin
                    if_pc_next    = pc_q;
                    pc_next       = pc_q + 32'd4;
                    if_valid_next = 1'b1;
                end
            end
            TRAP: begin
                state_next = TRAP;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

endmodule
